// File: rtl/adc_snap_ctrl.sv
// -----------------------------------------------------------------------------
// adc_snap_ctrl
//
// Snapshot capture controller. Once armed, the first cycle carrying both
// trigger and adc_valid starts a capture. Every valid ADC sample is packed,
// four per BRAM word with sample 0 in the LSBs. Each full word is written to
// consecutive BRAM addresses starting at 0. After CAPTURE_WORDS words have
// been written the block parks in DONE, where the snapshot can be read back
// over the BRAM's other port. It stays in DONE until it is re-armed.
//
// Ports
//   fabric_clk  : single clock, rising edge
//   fabric_rst  : asynchronous, active-high reset
//   arm         : single-cycle request to arm (honoured in IDLE and DONE only)
//   trigger     : level; starts the capture while armed (needs adc_valid too)
//   adc_valid   : qualifies adc_data
//   adc_data    : one ADC sample
//   bram_we     : one-cycle write strobe to the BRAM fabric port
//   bram_addr   : BRAM fabric-port address (current write address)
//   bram_data   : BRAM fabric-port write data (packed word)
//   busy        : high while ARMED or CAPTURE
//   done        : high in DONE (snapshot complete)
//   word_count  : words written in the current / last snapshot
// -----------------------------------------------------------------------------
module adc_snap_ctrl #(
    parameter int ADC_DATA_WIDTH = 8,
    parameter int RAM_DATA_WIDTH = 32,   // must equal 4*ADC_DATA_WIDTH
    parameter int RAM_ADDR_WIDTH = 8,
    parameter int CAPTURE_WORDS  = 256   // 1 .. 2**RAM_ADDR_WIDTH
) (
    input  logic                      fabric_clk,
    input  logic                      fabric_rst,
    input  logic                      arm,
    input  logic                      trigger,
    input  logic                      adc_valid,
    input  logic [ADC_DATA_WIDTH-1:0] adc_data,
    output logic                      bram_we,
    output logic [RAM_ADDR_WIDTH-1:0] bram_addr,
    output logic [RAM_DATA_WIDTH-1:0] bram_data,
    output logic                      busy,
    output logic                      done,
    output logic [RAM_ADDR_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // word_count value while the last word of the snapshot is being written
    localparam logic [RAM_ADDR_WIDTH:0] LAST_WORD = (RAM_ADDR_WIDTH+1)'(CAPTURE_WORDS - 1);

    state_t                    state_q, state_d;
    logic [1:0]                slot_q, slot_d;       // next lane to fill in the packer
    logic [RAM_DATA_WIDTH-1:0] pack_q, pack_d;
    logic [RAM_DATA_WIDTH-1:0] pack_ins;             // packer with adc_data dropped into slot_q
    logic                      bram_we_q, bram_we_d;
    logic [RAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [RAM_DATA_WIDTH-1:0] bram_data_q, bram_data_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [RAM_ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic                      final_write;

    // Lane insert: only the lane selected by slot_q takes the new sample.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign pack_ins[gi*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] =
                (slot_q == 2'(gi)) ? adc_data
                                   : pack_q[gi*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
        end
    endgenerate

    // The cycle in which the last word is on the BRAM port. Samples arriving
    // here belong to no word of this snapshot and are dropped.
    assign final_write = bram_we_q && (word_count_q == LAST_WORD);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        pack_d       = pack_q;
        bram_we_d    = 1'b0;
        bram_addr_d  = bram_addr_q;
        bram_data_d  = bram_data_q;
        word_count_d = word_count_q;

        // Address and count advance the cycle after each write. After the
        // final write of a full-depth snapshot the address wraps to 0, but
        // no write follows, so nothing is overwritten.
        if (bram_we_q) begin
            bram_addr_d  = bram_addr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d      = ST_ARMED;
                    slot_d       = 2'd0;
                    pack_d       = '0;
                    bram_addr_d  = '0;
                    word_count_d = '0;
                end
            end
            ST_ARMED: begin
                // slot_q is 0 here, so the trigger sample lands in lane 0.
                if (trigger && adc_valid) begin
                    state_d = ST_CAPTURE;
                    pack_d  = pack_ins;
                    slot_d  = 2'd1;
                end
            end
            ST_CAPTURE: begin
                if (final_write) begin
                    state_d = ST_DONE;
                end else if (adc_valid) begin
                    pack_d = pack_ins;
                    slot_d = slot_q + 2'd1;
                    if (slot_q == 2'd3) begin
                        bram_we_d   = 1'b1;
                        bram_data_d = pack_ins;
                    end
                end
            end
            ST_DONE: begin
                if (arm) begin
                    state_d      = ST_ARMED;
                    slot_d       = 2'd0;
                    pack_d       = '0;
                    bram_addr_d  = '0;
                    word_count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge fabric_clk or posedge fabric_rst) begin
        if (fabric_rst) begin
            state_q      <= ST_IDLE;
            slot_q       <= 2'd0;
            pack_q       <= '0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            pack_q       <= pack_d;
            bram_we_q    <= bram_we_d;
            bram_addr_q  <= bram_addr_d;
            bram_data_q  <= bram_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            word_count_q <= word_count_d;
        end
    end

    assign bram_we    = bram_we_q;
    assign bram_addr  = bram_addr_q;
    assign bram_data  = bram_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign word_count = word_count_q;

endmodule
